// File: rtl/streaming_differencer_if.sv
// -----------------------------------------------------------------------------
// streaming_differencer_if
//   Bundles the two streams of the differencer. Running sums arrive on the
//   upstream valid/ready pair. Recovered samples leave on the downstream
//   valid/ready pair, together with their frame and status flags.
//
//   slave  : view used by streaming_differencer
//            in : sum_in, sum_valid, frame_start, data_ready
//            out: sum_ready, data_out, data_valid, frame_last, range_err,
//                 sample_cnt
//   master : view used by whatever drives sums and consumes samples
//            (the opposite directions)
// -----------------------------------------------------------------------------
interface streaming_differencer_if #(
   parameter int SUM_W     = 32,
   parameter int DATA_W    = 16,
   parameter int FRAME_LEN = 16
);
   localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

   logic [SUM_W-1:0]  sum_in;
   logic              sum_valid;
   logic              sum_ready;
   logic              frame_start;
   logic [DATA_W-1:0] data_out;
   logic              data_valid;
   logic              data_ready;
   logic              frame_last;
   logic              range_err;
   logic [CNT_W-1:0]  sample_cnt;

   modport slave (
      input  sum_in, sum_valid, frame_start, data_ready,
      output sum_ready, data_out, data_valid, frame_last, range_err, sample_cnt
   );

   modport master (
      output sum_in, sum_valid, frame_start, data_ready,
      input  sum_ready, data_out, data_valid, frame_last, range_err, sample_cnt
   );
endinterface

// File: rtl/streaming_differencer.sv
// -----------------------------------------------------------------------------
// streaming_differencer
//   Recovers unsigned samples from a stream of running sums:
//   data_out = sum[n] - sum[n-1]. The subtraction is done modulo 2^SUM_W, so
//   wrap of the running sum is transparent. The predecessor sum restarts at
//   zero on every frame boundary (after FRAME_LEN samples, or on frame_start).
//   A difference that does not fit in DATA_W bits saturates to all-ones and
//   sets the sticky range_err flag.
//
//   Ports
//     clk    : rising-edge clock
//     reset  : asynchronous, active-high reset
//     link   : streaming_differencer_if.slave
//              sum_in/sum_valid/sum_ready  upstream running sums
//              frame_start                 next accepted sum opens a frame
//              data_out/data_valid/data_ready  recovered samples (one
//                                          registered output stage)
//              frame_last                  data_out closes its frame
//              range_err                   sticky saturation flag
//              sample_cnt                  index of next sample in the frame
// -----------------------------------------------------------------------------
module streaming_differencer #(
   parameter int SUM_W     = 32,
   parameter int DATA_W    = 16,
   parameter int FRAME_LEN = 16
) (
   input logic                   clk,
   input logic                   reset,
   streaming_differencer_if.slave link
);

   localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [0:0] {
      ST_FIRST = 1'b0,   // predecessor sum is treated as zero
      ST_RUN   = 1'b1    // predecessor sum is prev_r
   } state_t;

   state_t            state_r, state_nxt_s;
   logic [SUM_W-1:0]  prev_r, prev_nxt_s, prev_eff_s, diff_s;
   logic [CNT_W-1:0]  cnt_r, cnt_nxt_s, cnt_eff_s;
   logic [DATA_W-1:0] data_out_r, sample_s;
   logic              data_valid_r, frame_last_r, range_err_r;
   logic              sum_ready_s, accept_s, last_s, fits_s;

   // True when the upper bits of a difference are clear, so it fits in DATA_W.
   function automatic logic diff_fits(input logic [SUM_W-1:0] diff);
      diff_fits = (diff[SUM_W-1:DATA_W] == {(SUM_W-DATA_W){1'b0}});
   endfunction

   // Clamp a difference to DATA_W bits, saturating to all-ones on overflow.
   function automatic logic [DATA_W-1:0] sat_sample(input logic [SUM_W-1:0] diff);
      if (diff_fits(diff)) begin
         sat_sample = diff[DATA_W-1:0];
      end else begin
         sat_sample = {DATA_W{1'b1}};
      end
   endfunction

   // Upstream handshake: the single output stage frees up when it is empty
   // or is being drained this cycle.
   assign sum_ready_s = !data_valid_r || link.data_ready;
   assign accept_s    = link.sum_valid && sum_ready_s;

   // Next-state, predecessor and frame-counter logic.
   always_comb begin
      state_nxt_s = state_r;
      prev_nxt_s  = prev_r;
      // frame_start makes the sum offered alongside it the first of a frame
      cnt_eff_s   = link.frame_start ? {CNT_W{1'b0}} : cnt_r;
      case (state_r)
         ST_FIRST: prev_eff_s = {SUM_W{1'b0}};
         ST_RUN:   prev_eff_s = link.frame_start ? {SUM_W{1'b0}} : prev_r;
         default:  prev_eff_s = {SUM_W{1'b0}};
      endcase
      diff_s    = link.sum_in - prev_eff_s;
      fits_s    = diff_fits(diff_s);
      sample_s  = sat_sample(diff_s);
      last_s    = (cnt_eff_s == LAST_IDX);
      cnt_nxt_s = cnt_eff_s;
      if (accept_s) begin
         if (last_s) begin
            // frame closes: next sum starts from a zero predecessor
            state_nxt_s = ST_FIRST;
            prev_nxt_s  = {SUM_W{1'b0}};
            cnt_nxt_s   = {CNT_W{1'b0}};
         end else begin
            state_nxt_s = ST_RUN;
            prev_nxt_s  = link.sum_in;
            cnt_nxt_s   = cnt_eff_s + CNT_ONE;
         end
      end else if (link.frame_start) begin
         // idle frame_start: only re-arm the frame
         state_nxt_s = ST_FIRST;
         prev_nxt_s  = {SUM_W{1'b0}};
      end else begin
         state_nxt_s = state_r;
      end
   end

   // FSM state, predecessor sum and frame counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_FIRST;
         prev_r  <= {SUM_W{1'b0}};
         cnt_r   <= {CNT_W{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         prev_r  <= prev_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   // Output stage: loads on accept, empties after a transfer with no refill.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_out_r   <= {DATA_W{1'b0}};
         data_valid_r <= 1'b0;
         frame_last_r <= 1'b0;
         range_err_r  <= 1'b0;
      end else begin
         if (accept_s) begin
            data_out_r   <= sample_s;
            data_valid_r <= 1'b1;
            frame_last_r <= last_s;
            if (!fits_s) begin
               range_err_r <= 1'b1;
            end
         end else if (link.data_ready) begin
            data_valid_r <= 1'b0;
         end
      end
   end

   assign link.sum_ready  = sum_ready_s;
   assign link.data_out   = data_out_r;
   assign link.data_valid = data_valid_r;
   assign link.frame_last = frame_last_r;
   assign link.range_err  = range_err_r;
   assign link.sample_cnt = cnt_r;

endmodule

// File: tb/tb_streaming_differencer.sv
// -----------------------------------------------------------------------------
// tb_streaming_differencer
//   Table of {sum, frame_start, expected sample, last, range_err, sample_cnt}
//   records applied in order. Expected samples go into a scoreboard queue when
//   the sum is accepted and are compared when data_out transfers. Hand-written
//   sequences cover backpressure, idle frame_start and reset mid-frame.
// -----------------------------------------------------------------------------
module tb_streaming_differencer;

   typedef struct {
      logic [31:0] sum;
      logic        fs;
      logic [15:0] data;
      logic        last;
      logic        err;
      logic [3:0]  cnt;
   } vec_t;

   typedef struct {
      logic [15:0] data;
      logic        last;
      logic        err;
   } exp_t;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_bad;
   vec_t vecs[30];
   exp_t sb[$];
   exp_t mon_e;

   streaming_differencer_if #(.SUM_W(32), .DATA_W(16), .FRAME_LEN(16)) link ();

   streaming_differencer #(.SUM_W(32), .DATA_W(16), .FRAME_LEN(16)) dut (
      .clk   (clk),
      .reset (reset),
      .link  (link.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   function automatic void set_vec(input int i, input logic [31:0] s, input logic fs,
                                   input logic [15:0] d, input logic l, input logic e,
                                   input logic [3:0] c);
      vecs[i].sum  = s;
      vecs[i].fs   = fs;
      vecs[i].data = d;
      vecs[i].last = l;
      vecs[i].err  = e;
      vecs[i].cnt  = c;
   endfunction

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   // Offer vecs[i]; must be called just after a rising edge.
   task automatic send(input int i);
      int waited;
      link.sum_in      = vecs[i].sum;
      link.sum_valid   = 1'b1;
      link.frame_start = vecs[i].fs;
      waited = 0;
      @(negedge clk);
      while (!link.sum_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!link.sum_ready) begin
         chk($sformatf("accept_timeout[%0d]", i), 32'd0, 32'd1);
         link.sum_valid   = 1'b0;
         link.frame_start = 1'b0;
      end else begin
         sb.push_back('{vecs[i].data, vecs[i].last, vecs[i].err});
         sync();
         link.sum_valid   = 1'b0;
         link.frame_start = 1'b0;
         chk($sformatf("sample_cnt[%0d]", i), 32'(link.sample_cnt), 32'(vecs[i].cnt));
      end
   endtask

   // Assert reset between edges and check it acts immediately.
   task automatic do_reset();
      reset = 1'b1;
      #1;
      chk("rst_data_out",   32'(link.data_out),   32'd0);
      chk("rst_data_valid", 32'(link.data_valid), 32'd0);
      chk("rst_frame_last", 32'(link.frame_last), 32'd0);
      chk("rst_range_err",  32'(link.range_err),  32'd0);
      chk("rst_sample_cnt", 32'(link.sample_cnt), 32'd0);
      sb.delete();
      sync();
      reset = 1'b0;
      sync();
   endtask

   // Scoreboard: compare every output transfer against the oldest expectation.
   always @(negedge clk) begin
      if (!reset && link.data_valid && link.data_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_output", 32'(link.data_out), 32'hdead_beef);
         end else begin
            mon_e = sb.pop_front();
            chk("data_out",   32'(link.data_out),   32'(mon_e.data));
            chk("frame_last", 32'(link.frame_last), 32'(mon_e.last));
            chk("range_err",  32'(link.range_err),  32'(mon_e.err));
         end
      end
   end

   initial begin
      n_cmp = 0;
      n_bad = 0;
      reset = 1'b0;
      link.sum_in      = 32'd0;
      link.sum_valid   = 1'b0;
      link.frame_start = 1'b0;
      link.data_ready  = 1'b1;

      // triangular sums 1,3,...,136 -> samples 1..16
      for (int k = 1; k <= 16; k++) begin
         set_vec(k - 1, 32'(k * (k + 1) / 2), 1'b0, 16'(k), (k == 16), 1'b0, 4'(k % 16));
      end
      set_vec(16, 32'd5,          1'b0, 16'd5,      1'b0, 1'b0, 4'd1);
      set_vec(17, 32'd12,         1'b0, 16'd7,      1'b0, 1'b0, 4'd2);
      set_vec(18, 32'd20,         1'b0, 16'd8,      1'b0, 1'b0, 4'd3);
      set_vec(19, 32'd30,         1'b0, 16'd10,     1'b0, 1'b0, 4'd4);
      set_vec(20, 32'd45,         1'b0, 16'd15,     1'b0, 1'b0, 4'd5);
      set_vec(21, 32'd50,         1'b1, 16'd50,     1'b0, 1'b0, 4'd1);
      set_vec(22, 32'd53,         1'b0, 16'd3,      1'b0, 1'b0, 4'd2);
      set_vec(23, 32'hFFFF_FFFE,  1'b0, 16'hFFFF,   1'b0, 1'b1, 4'd1);
      set_vec(24, 32'h0000_0003,  1'b0, 16'd5,      1'b0, 1'b1, 4'd2);
      set_vec(25, 32'h0000_0010,  1'b0, 16'h0010,   1'b0, 1'b0, 4'd1);
      set_vec(26, 32'h0001_0020,  1'b0, 16'hFFFF,   1'b0, 1'b1, 4'd2);
      set_vec(27, 32'h0001_0030,  1'b0, 16'h0010,   1'b0, 1'b1, 4'd3);
      set_vec(28, 32'h0001_0130,  1'b0, 16'h0100,   1'b0, 1'b1, 4'd4);
      set_vec(29, 32'd7,          1'b0, 16'd7,      1'b0, 1'b0, 4'd1);

      sync();
      do_reset();
      chk("rst_sum_ready", 32'(link.sum_ready), 32'd1);

      // full frame, frame roll, then start of the backpressure stream
      for (int i = 0; i <= 18; i++) begin
         send(i);
      end

      // stall downstream for 3 cycles with a sum pending
      link.data_ready  = 1'b0;
      link.sum_in      = vecs[19].sum;
      link.sum_valid   = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("stall_sum_ready",  32'(link.sum_ready),  32'd0);
         chk("stall_data_valid", 32'(link.data_valid), 32'd1);
         chk("stall_data_out",   32'(link.data_out),   32'd8);
         sync();
      end
      link.data_ready = 1'b1;
      for (int i = 19; i <= 22; i++) begin
         send(i);
      end

      // idle frame_start re-arms the frame
      link.frame_start = 1'b1;
      sync();
      link.frame_start = 1'b0;
      chk("idle_fs_cnt", 32'(link.sample_cnt), 32'd0);
      send(23);
      send(24);
      sync();

      // overflow with a clean range_err
      do_reset();
      for (int i = 25; i <= 28; i++) begin
         send(i);
      end

      // reset mid-frame while the output holds a sample
      link.data_ready = 1'b0;
      #2;
      chk("pre_rst_valid", 32'(link.data_valid), 32'd1);
      do_reset();
      link.data_ready = 1'b1;
      send(29);
      repeat (3) sync();
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
